// File: rtl/ncpu32k_ifu.sv
// Instruction fetch unit: issues word-aligned fetch PCs to imem, buffers responses in a
// 2-entry FIFO and presents them to the pre-decoder, handling jump/flush redirects.
module ncpu32k_ifu #(
   parameter int AW = 32,
   parameter int IW = 32,
   parameter logic [AW-3:0] CONFIG_ERST_VECTOR = 30'h20000000
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          imem_req_vld,
   input  logic          imem_req_rdy,
   output logic [AW-3:0] imem_req_addr,
   input  logic          imem_rsp_vld,
   input  logic [IW-1:0] imem_rsp_insn,
   input  logic          imem_rsp_EITM,
   input  logic          imem_rsp_EIPF,
   output logic          ifu_insn_vld,
   input  logic          ifu_insn_rdy,
   output logic [IW-1:0] ifu_insn,
   output logic [AW-3:0] ifu_pc,
   output logic          ifu_EITM,
   output logic          ifu_EIPF,
   input  logic          jmprel,
   input  logic [AW-3:0] jmprel_tgt,
   input  logic          exc_flush,
   input  logic [AW-3:0] exc_flush_tgt
);

   localparam int PW = AW - 2;

   typedef struct packed {
      logic [IW-1:0] insn;
      logic [PW-1:0] pc;
      logic          eitm;
      logic          eipf;
   } entry_t;

   logic [PW-1:0] pc_q, pc_d;
   logic [1:0]    outst_q, outst_d;
   logic [1:0]    kill_q, kill_d;
   logic [PW-1:0] tag_q [2];
   logic          tagWr_q, tagWr_d, tagRd_q, tagRd_d;
   entry_t        fifo_q [2];
   logic          fifoWr_q, fifoWr_d, fifoRd_q, fifoRd_d;
   logic [1:0]    fifoCnt_q, fifoCnt_d;

   logic   insnFire, redir, credit, reqFire, rspKill, fifoPush, fifoPop;
   entry_t head, newEntry;

   assign insnFire = ifu_insn_vld & ifu_insn_rdy;
   assign redir    = exc_flush | (jmprel & insnFire);
   // Credit counts in-flight fetches plus buffered ones so a response always has a slot.
   assign credit   = ({1'b0, outst_q} + {1'b0, fifoCnt_q}) < 3'd2;
   assign imem_req_vld  = rst_n & ~redir & credit;
   assign imem_req_addr = pc_q;
   assign reqFire  = imem_req_vld & imem_req_rdy;
   assign rspKill  = imem_rsp_vld & (kill_q != 2'd0);
   assign fifoPush = imem_rsp_vld & ~rspKill & ~redir;
   assign fifoPop  = insnFire;

   assign newEntry = '{insn: imem_rsp_insn, pc: tag_q[tagRd_q],
                       eitm: imem_rsp_EITM, eipf: imem_rsp_EIPF};

   assign head         = fifo_q[fifoRd_q];
   assign ifu_insn_vld = (fifoCnt_q != 2'd0);
   assign ifu_insn     = ifu_insn_vld ? head.insn : '0;
   assign ifu_pc       = ifu_insn_vld ? head.pc   : '0;
   assign ifu_EITM     = ifu_insn_vld & head.eitm;
   assign ifu_EIPF     = ifu_insn_vld & head.eipf;

   always_comb begin
      pc_d      = pc_q;
      outst_d   = outst_q + {1'b0, reqFire} - {1'b0, imem_rsp_vld};
      kill_d    = kill_q;
      tagWr_d   = tagWr_q ^ reqFire;
      tagRd_d   = tagRd_q ^ imem_rsp_vld;
      fifoWr_d  = fifoWr_q ^ fifoPush;
      fifoRd_d  = fifoRd_q ^ fifoPop;
      fifoCnt_d = fifoCnt_q + {1'b0, fifoPush} - {1'b0, fifoPop};
      if (redir) begin
         pc_d      = exc_flush ? exc_flush_tgt : jmprel_tgt;
         // Every fetch still in flight after this cycle belongs to the wrong path.
         kill_d    = outst_q - {1'b0, imem_rsp_vld};
         fifoWr_d  = fifoWr_q;
         fifoRd_d  = fifoWr_q;
         fifoCnt_d = 2'd0;
      end else begin
         if (reqFire) pc_d = pc_q + 1'b1;
         if (rspKill) kill_d = kill_q - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= CONFIG_ERST_VECTOR;
         outst_q   <= 2'd0;
         kill_q    <= 2'd0;
         tagWr_q   <= 1'b0;
         tagRd_q   <= 1'b0;
         fifoWr_q  <= 1'b0;
         fifoRd_q  <= 1'b0;
         fifoCnt_q <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            tag_q[i]  <= '0;
            fifo_q[i] <= '0;
         end
      end else begin
         pc_q      <= pc_d;
         outst_q   <= outst_d;
         kill_q    <= kill_d;
         tagWr_q   <= tagWr_d;
         tagRd_q   <= tagRd_d;
         fifoWr_q  <= fifoWr_d;
         fifoRd_q  <= fifoRd_d;
         fifoCnt_q <= fifoCnt_d;
         if (reqFire) tag_q[tagWr_q] <= pc_q;
         if (fifoPush) fifo_q[fifoWr_q] <= newEntry;
      end
   end

   assert property (@(posedge clk) disable iff (!rst_n)
      !(fifoPush && !fifoPop && fifoCnt_q == 2'd2));

endmodule
